// File: rtl/mem_pkg.sv
// Shared constants and types for the CPU memory responder.
// Includes bus command codes, the I/O address map, and the responder state.
package mem_pkg;

  localparam logic [1:0] MREAD  = 2'd1;
  localparam logic [1:0] MNONE  = 2'd2;
  localparam logic [1:0] MWRITE = 2'd3;

  localparam logic [8:0] ADDR_LED = 9'h100;
  localparam logic [8:0] ADDR_SW  = 9'h140;

  typedef enum logic {LOAD, SERVE} state_t;

  // Source of read_data for the cycle after a command.
  typedef enum logic [1:0] {SEL_ZERO, SEL_RAM, SEL_SW} rd_sel_t;

endpackage

// File: rtl/mem_responder_if.sv
// CPU memory bus between the CPU (master) and the memory responder (slave).
// The CPU issues one command every cycle, and there is no stall.
// read_data carries the result of the previous cycle's MREAD.
interface mem_responder_if;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;

  modport master (output mem_cmd, output mem_addr, output write_data, input read_data);
  modport slave  (input mem_cmd, input mem_addr, input write_data, output read_data);
endinterface

// File: rtl/ram256x16.sv
// Single-port RAM with a synchronous write and a registered read.
// The read is read-first, so it can be inferred as block RAM.
module ram256x16 #(
  parameter int RAM_AW = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [RAM_AW-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata
);

  logic [15:0] mem [1<<RAM_AW];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: a boot-load phase fills RAM, then the CPU bus is served.
// The bus has one-cycle read latency. An LED register and a switch port are memory mapped.
module mem_responder
  import mem_pkg::*;
#(
  parameter bit BOOT_LOAD = 1'b1,
  parameter int RAM_AW    = 8
) (
  input  logic              clk,
  input  logic              reset,
  mem_responder_if.slave    bus,
  input  logic [7:0]        sw,
  output logic [7:0]        led,
  // Boot port handshake: a word transfers on any edge where ld_valid and ld_ready are both high.
  // ld_ready depends only on state, never on ld_valid.
  input  logic              ld_valid,
  input  logic [15:0]       ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              busy,
  output state_t            state_dbg
);

  localparam logic [RAM_AW-1:0] PTR_MAX = '1;

  state_t            state, state_next;
  logic [RAM_AW-1:0] ptr, ptr_next;
  rd_sel_t           sel_q, sel_next;
  logic [7:0]        sw_q;
  logic              ram_we, led_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [15:0]       ram_wdata, ram_rdata;

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    sel_next   = SEL_ZERO;
    ram_we     = 1'b0;
    led_we     = 1'b0;
    ram_addr   = bus.mem_addr[RAM_AW-1:0];
    ram_wdata  = bus.write_data;
    case (state)
      LOAD: begin
        ram_addr  = ptr;
        ram_wdata = ld_data;
        if (ld_valid) begin
          ram_we = 1'b1;
          if (ld_last || ptr == PTR_MAX) state_next = SERVE;
          // The pointer stops at the top, so an overflowing load never wraps onto word 0.
          if (ptr != PTR_MAX) ptr_next = ptr + 1'b1;
        end
      end
      SERVE: begin
        case (bus.mem_cmd)
          MREAD: begin
            if (!bus.mem_addr[8])             sel_next = SEL_RAM;
            else if (bus.mem_addr == ADDR_SW) sel_next = SEL_SW;
          end
          MWRITE: begin
            if (!bus.mem_addr[8])              ram_we = 1'b1;
            else if (bus.mem_addr == ADDR_LED) led_we = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BOOT_LOAD ? LOAD : SERVE;
      ptr   <= '0;
      sel_q <= SEL_ZERO;
      sw_q  <= 8'h00;
      led   <= 8'h00;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
      sel_q <= sel_next;
      sw_q  <= sw;
      if (led_we) led <= bus.write_data[7:0];
    end
  end

  // A write is suppressed on the reset edge, so reset wins over a concurrent boot word.
  ram256x16 #(.RAM_AW(RAM_AW)) u_ram (
    .clk   (clk),
    .we    (ram_we && !reset),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    bus.read_data = 16'h0000;
    case (sel_q)
      SEL_RAM: bus.read_data = ram_rdata;
      SEL_SW:  bus.read_data = {8'h00, sw_q};
      default: ;
    endcase
  end

  assign ld_ready  = (state == LOAD);
  assign busy      = (state == LOAD);
  assign state_dbg = state;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder.
// Instance a uses boot load; instance b starts directly in SERVE.
module tb_mem_responder;
  import mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_a, reset_b;
  logic [7:0]  sw;
  logic [7:0]  led_a, led_b;
  logic        ld_valid_a, ld_last_a, ld_ready_a, busy_a;
  logic        ld_valid_b, ld_last_b, ld_ready_b, busy_b;
  logic [15:0] ld_data_a, ld_data_b;
  state_t      st_a, st_b;

  mem_responder_if bus_a();
  mem_responder_if bus_b();

  mem_responder #(.BOOT_LOAD(1'b1), .RAM_AW(8)) dut_a (
    .clk(clk), .reset(reset_a), .bus(bus_a), .sw(sw), .led(led_a),
    .ld_valid(ld_valid_a), .ld_data(ld_data_a), .ld_last(ld_last_a),
    .ld_ready(ld_ready_a), .busy(busy_a), .state_dbg(st_a)
  );

  mem_responder #(.BOOT_LOAD(1'b0), .RAM_AW(8)) dut_b (
    .clk(clk), .reset(reset_b), .bus(bus_b), .sw(sw), .led(led_b),
    .ld_valid(ld_valid_b), .ld_data(ld_data_b), .ld_last(ld_last_b),
    .ld_ready(ld_ready_b), .busy(busy_b), .state_dbg(st_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic cpu_a(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] wd);
    bus_a.mem_cmd = cmd; bus_a.mem_addr = addr; bus_a.write_data = wd;
    step();
  endtask

  task automatic cpu_b(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] wd);
    bus_b.mem_cmd = cmd; bus_b.mem_addr = addr; bus_b.write_data = wd;
    step();
  endtask

  task automatic offer_a(input logic [15:0] d, input logic last);
    ld_valid_a = 1'b1; ld_data_a = d; ld_last_a = last;
    step();
    ld_valid_a = 1'b0; ld_last_a = 1'b0;
  endtask

  task automatic reset_dut_a();
    reset_a = 1'b1;
    step();
    reset_a = 1'b0;
  endtask

  initial begin
    reset_a = 1'b1; reset_b = 1'b1; sw = 8'h00;
    ld_valid_a = 1'b0; ld_data_a = 16'h0; ld_last_a = 1'b0;
    ld_valid_b = 1'b0; ld_data_b = 16'h0; ld_last_b = 1'b0;
    bus_a.mem_cmd = MNONE; bus_a.mem_addr = 9'h0; bus_a.write_data = 16'h0;
    bus_b.mem_cmd = MNONE; bus_b.mem_addr = 9'h0; bus_b.write_data = 16'h0;
    step();
    step();
    reset_a = 1'b0; reset_b = 1'b0;

    // Reset state of both instances.
    check("a_rst_busy", 16'(busy_a), 16'h1);
    check("a_rst_ready", 16'(ld_ready_a), 16'h1);
    check("a_rst_rdata", bus_a.read_data, 16'h0);
    check("a_rst_led", 16'(led_a), 16'h0);
    check("b_rst_busy", 16'(busy_b), 16'h0);
    check("b_rst_ready", 16'(ld_ready_b), 16'h0);
    check("b_rst_state", 16'(st_b), 16'(SERVE));

    // Instance b: SERVE from the first cycle; boot pulses are ignored.
    sw = 8'h5A;
    cpu_b(MREAD, 9'h140, 16'h0);
    check("b_sw_read", bus_b.read_data, 16'h005A);
    ld_valid_b = 1'b1; ld_data_b = 16'h7777; ld_last_b = 1'b1;
    cpu_b(MWRITE, 9'h000, 16'h0001);
    cpu_b(MREAD, 9'h000, 16'h0);
    check("b_ram_rd", bus_b.read_data, 16'h0001);
    check("b_busy_ld", 16'(busy_b), 16'h0);
    ld_valid_b = 1'b0; ld_last_b = 1'b0;
    cpu_b(MNONE, 9'h000, 16'h0);

    // Instance a: boot load with gaps.
    offer_a(16'hA001, 1'b0);
    step();
    offer_a(16'hA002, 1'b0);
    step();
    step();
    check("a_busy_before_last", 16'(busy_a), 16'h1);
    offer_a(16'hA003, 1'b1);
    check("a_busy_after_last", 16'(busy_a), 16'h0);
    check("a_ready_after_last", 16'(ld_ready_a), 16'h0);
    check("a_load_rdata0", bus_a.read_data, 16'h0);
    cpu_a(MREAD, 9'h000, 16'h0); check("a_boot0", bus_a.read_data, 16'hA001);
    cpu_a(MREAD, 9'h001, 16'h0); check("a_boot1", bus_a.read_data, 16'hA002);
    cpu_a(MREAD, 9'h002, 16'h0); check("a_boot2", bus_a.read_data, 16'hA003);
    cpu_a(MREAD, 9'h002, 16'h0); check("a_boot2_hold", bus_a.read_data, 16'hA003);

    // Write/readback, then MNONE and cmd 0.
    cpu_a(MWRITE, 9'h005, 16'h1234); check("a_wr_rdata", bus_a.read_data, 16'h0);
    cpu_a(MREAD, 9'h005, 16'h0);     check("a_rd_after_wr", bus_a.read_data, 16'h1234);
    cpu_a(MNONE, 9'h005, 16'h0);     check("a_mnone", bus_a.read_data, 16'h0);
    cpu_a(2'd0, 9'h005, 16'h0);      check("a_cmd0", bus_a.read_data, 16'h0);

    // I/O map.
    cpu_a(MWRITE, 9'h100, 16'h00C3); check("a_led_wr", 16'(led_a), 16'h00C3);
    sw = 8'h3C;
    cpu_a(MREAD, 9'h140, 16'h0);     check("a_sw_rd", bus_a.read_data, 16'h003C);
    cpu_a(MREAD, 9'h100, 16'h0);     check("a_led_rd0", bus_a.read_data, 16'h0);
    cpu_a(MREAD, 9'h1FF, 16'h0);     check("a_unmapped_rd", bus_a.read_data, 16'h0);
    cpu_a(MWRITE, 9'h1FF, 16'hFFFF); check("a_unmapped_led", 16'(led_a), 16'h00C3);
    cpu_a(MREAD, 9'h0FF, 16'h0);
    cpu_a(MREAD, 9'h005, 16'h0);     check("a_unmapped_ram", bus_a.read_data, 16'h1234);

    // Overflow: 256 words without ld_last.
    reset_dut_a();
    check("a_ovf_rst_led", 16'(led_a), 16'h0);
    for (int i = 0; i < 256; i++) begin
      if (i == 255) check("a_ovf_busy_at_255", 16'(busy_a), 16'h1);
      ld_valid_a = 1'b1; ld_data_a = 16'hB000 + 16'(i); ld_last_a = 1'b0;
      step();
    end
    ld_data_a = 16'hDEAD;
    check("a_ovf_busy", 16'(busy_a), 16'h0);
    check("a_ovf_ready", 16'(ld_ready_a), 16'h0);
    step();
    ld_valid_a = 1'b0;
    cpu_a(MREAD, 9'h000, 16'h0); check("a_ovf_ram0", bus_a.read_data, 16'hB000);
    cpu_a(MREAD, 9'h0FF, 16'h0); check("a_ovf_ram255", bus_a.read_data, 16'hB0FF);

    // Reset mid-load; a boot word offered during the reset cycle is dropped.
    reset_dut_a();
    offer_a(16'hC000, 1'b0);
    offer_a(16'hC001, 1'b0);
    ld_valid_a = 1'b1; ld_data_a = 16'hEEEE;
    reset_dut_a();
    check("a_mid_busy", 16'(busy_a), 16'h1);
    offer_a(16'hD000, 1'b1);
    check("a_mid_state", 16'(st_a), 16'(SERVE));
    cpu_a(MREAD, 9'h000, 16'h0); check("a_mid_ram0", bus_a.read_data, 16'hD000);
    cpu_a(MREAD, 9'h001, 16'h0); check("a_mid_ram1", bus_a.read_data, 16'hC001);
    cpu_a(MREAD, 9'h002, 16'h0); check("a_mid_ram2", bus_a.read_data, 16'hB002);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
